addertree_feeder: RTL
=====================

Name: addertree_feeder

Overview:
- Front-end sequencer for the pipelined adder tree.
- Accepts a serial valid/ready stream of signed samples and fills an NINPUTS-entry vector buffer. Short frames are zero-padded.
- Pulses go to the tree, holds the vector stable until the tree flags outReady, then captures the sum and presents it on an output valid/ready handshake.
- Sits between the sample source and the adder tree. Its outputs connect to the tree's inputNum/go, and tree outReady/result return to it.

Parameters:
- NINPUTS, 1024, vector length; equals the tree's NINPUTS; power of two, >= 2.
- IWIDTH, 8, sample width, signed two's complement; equals the tree's IWIDTH.
- OWIDTH, 16, result width; equals the tree's OWIDTH.
- CW (localparam), ceil(log2(NINPUTS+1)), width of the index and sample count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  feeder can accept a sample.
- in_data  in  IWIDTH  signed sample.
- in_last  in  1  marks the final sample of a frame.
- vec  out  NINPUTS x IWIDTH  signed vector to the tree; registered.
- go  out  1  one-cycle start pulse to the tree.
- tree_ready  in  1  tree outReady, a one-cycle pulse.
- tree_result  in  OWIDTH  tree result.
- out_valid  out  1  captured sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  OWIDTH  captured sum, bit-exact copy of tree_result.
- out_count  out  CW  number of real (non-pad) samples in the frame.
- busy  out  1  high in every state except FILL.

Behaviour:
- Reset (rst=0, async):
  - state=FILL, idx=0, count=0.
  - All vec entries 0.
  - go=0, out_valid=0, out_data=0, out_count=0, busy=0.
  - in_ready=1 from the first cycle after reset deassertion.
  - Reset mid-frame or mid-sum discards all work. Any tree_ready arriving after reset is ignored, since state≠WAIT.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: vec[idx]<=in_data, count<=idx+1.
  - If idx==NINPUTS-1 → LAUNCH; in_last is ignored here, since the frame ends at NINPUTS samples regardless.
  - Else if in_last → idx<=idx+1, go to ZPAD.
  - Else idx<=idx+1.
- ZPAD:
  - in_ready=0.
  - Each cycle vec[idx]<=0 and idx<=idx+1.
  - After writing entry NINPUTS-1 → LAUNCH.
  - Costs exactly NINPUTS-count cycles, so stale data from a previous frame is never summed.
- LAUNCH:
  - go=1 for exactly one cycle, then → WAIT.
  - vec is frozen from entry to LAUNCH until the return to FILL.
- WAIT:
  - go=0.
  - On tree_ready=1: out_data<=tree_result, out_count<=count, go to OUT.
  - No timeout: the feeder waits indefinitely.
- OUT:
  - out_valid=1; out_data and out_count hold stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid<=0, idx<=0, count<=0, go to FILL.
  - in_ready stays 0 throughout OUT; there is no overlap of the next frame with an unaccepted result.
- Latency:
  - Last accepted sample → go: 1 + (NINPUTS-count) cycles.
  - go → capture = tree latency (outReady edge) + 1.
  - Capture → out_valid: registered, so out_valid is high the cycle after tree_ready.
- Simultaneous in_valid and in_last on entry NINPUTS-1: treated as a full frame, with no ZPAD.
- in_last on a sample with in_valid=0 has no effect.
- Inputs outside their owning state (in_valid outside FILL, tree_ready outside WAIT, out_ready outside OUT) have no effect.
- The feeder does no arithmetic on the result; sign handling and width are as produced by the tree.

Test Plan:
(NINPUTS=8, IWIDTH=8, OWIDTH=16, tree instantiated behind the feeder)
- Full frame: samples 1..8 back-to-back, in_last on the 8th, out_ready=1.
  → one go pulse one cycle after the 8th handshake, out_valid with out_data=36 (0x0024), out_count=8, then in_ready=1 the following cycle.
- Short frame: first a full frame of all 0x7F (consumed), then 10,20,30 with in_last on 30.
  → exactly 5 ZPAD cycles, go once, out_data=60, out_count=3.
  → Confirms the stale 0x7F entries are cleared.
- Output backpressure: full frame 1..8 with out_ready=0 for 10 cycles.
  → out_valid and out_data=36 held stable all 10 cycles, in_ready=0, no second go.
  → Release out_ready: FILL re-entered one cycle later.
- Input gaps: samples 1..8 with in_valid toggling every other cycle.
  → only valid beats are written, out_data=36.
  → vec is unchanged between go and capture (monitor asserts stability).
- Reset mid-sum: assert rst low for 1 cycle during WAIT.
  → immediately go=0, out_valid=0, vec all 0, in_ready=1 after release.
  → The late tree_ready produces no out_valid.
  → A next frame of eight 2's gives out_data=16.
- Early last ignored at full length: in_last asserted on every sample.
  → ZPAD after the first sample (out_count=1, out_data=first sample).
  → in_last on the 8th sample of a full frame yields out_count=8 with no ZPAD.

Source files
------------

// File: rtl/addertree_feeder.sv
// Front-end sequencer for the pipelined adder tree: gathers a serial sample
// stream into a zero-padded vector, launches the tree and hands back its sum.

module addertree_feeder_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (we) q <= d;
    end
endmodule

module addertree_feeder #(
    parameter int NINPUTS = 1024,
    parameter int IWIDTH  = 8,
    parameter int OWIDTH  = 16,
    localparam int CW     = $clog2(NINPUTS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IWIDTH-1:0]                in_data,
    input  logic                             in_last,
    output logic [NINPUTS-1:0][IWIDTH-1:0]   vec,
    output logic                             go,
    input  logic                             tree_ready,
    input  logic [OWIDTH-1:0]                tree_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OWIDTH-1:0]                out_data,
    output logic [CW-1:0]                    out_count,
    output logic                             busy
);
    typedef enum logic [2:0] {FILL, ZPAD, LAUNCH, WAIT, OUT} state_t;

    localparam logic [CW-1:0] LAST = CW'(NINPUTS - 1);

    state_t            state;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     count;
    logic              wr;
    logic [IWIDTH-1:0] wdata;

    // ZPAD overwrites the tail with zeros so a short frame never sums stale entries
    assign wr    = (in_ready && in_valid) || (state == ZPAD);
    assign wdata = (state == ZPAD) ? '0 : in_data;

    for (genvar i = 0; i < NINPUTS; i++) begin : g_lane
        addertree_feeder_lane #(.W(IWIDTH)) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (wr && (idx == CW'(i))),
            .d   (wdata),
            .q   (vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            idx       <= '0;
            count     <= '0;
            go        <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        count <= idx + 1'b1;
                        if (idx == LAST) begin
                            state    <= LAUNCH;
                            go       <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (in_last) begin
                                state    <= ZPAD;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
                        end
                    end
                end
                ZPAD: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= LAUNCH;
                        go    <= 1'b1;
                    end
                end
                LAUNCH: begin
                    go    <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tree_ready) begin
                        out_data  <= tree_result;
                        out_count <= count;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
